// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment scanner: segment patterns,
// digit-index type and the latched BCD value layout.
package seg7_pkg;

  localparam int unsigned IdxW = 2;

  typedef logic [IdxW-1:0] idx_t;

  typedef struct packed {
    logic       sign;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_val_t;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] Seg0     = 7'b1000000;
  localparam logic [6:0] Seg1     = 7'b1111001;
  localparam logic [6:0] Seg2     = 7'b0100100;
  localparam logic [6:0] Seg3     = 7'b0110000;
  localparam logic [6:0] Seg4     = 7'b0011001;
  localparam logic [6:0] Seg5     = 7'b0010010;
  localparam logic [6:0] Seg6     = 7'b0000010;
  localparam logic [6:0] Seg7     = 7'b1111000;
  localparam logic [6:0] Seg8     = 7'b0000000;
  localparam logic [6:0] Seg9     = 7'b0010000;
  localparam logic [6:0] SegDash  = 7'b0111111;
  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] SegErr   = 7'b0000110;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low 7-segment pattern; non-decimal codes show 'E'.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SegErr;
    case (bcd_i)
      4'd0:    seg_o = Seg0;
      4'd1:    seg_o = Seg1;
      4'd2:    seg_o = Seg2;
      4'd3:    seg_o = Seg3;
      4'd4:    seg_o = Seg4;
      4'd5:    seg_o = Seg5;
      4'd6:    seg_o = Seg6;
      4'd7:    seg_o = Seg7;
      4'd8:    seg_o = Seg8;
      4'd9:    seg_o = Seg9;
      default: seg_o = SegErr;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed display scanner with double-buffered value, leading-zero
// suppression and a blank slot on every digit change to avoid ghosting.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter logic [15:0] DIV = 16'd25000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sign,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic       data_ready,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       valid
);

  logic [15:0] cnt_q, cnt_d;
  idx_t        idx_q, idx_d;
  bcd_val_t    pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;
  bcd_val_t    disp_q, disp_d;
  logic        valid_q, valid_d;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;

  logic       tick;
  logic       wrap;
  logic [3:0] nib;
  logic [6:0] dec_seg;

  always_comb begin
    tick  = (cnt_q == DIV - 16'd1);
    wrap  = tick && (&idx_q);
    cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
    idx_d = idx_q + idx_t'(tick);

    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    disp_d     = disp_q;
    valid_d    = valid_q;
    // Commit first so a same-cycle data_ready becomes the next pending value
    if (wrap && pend_vld_q) begin
      disp_d     = pend_q;
      valid_d    = 1'b1;
      pend_vld_d = 1'b0;
    end
    if (data_ready) begin
      pend_d     = '{sign: sign, hundreds: hundreds, tens: tens, ones: ones};
      pend_vld_d = 1'b1;
    end
  end

  always_comb begin
    nib = 4'd0;
    unique case (idx_q)
      2'd0:    nib = disp_q.ones;
      2'd1:    nib = disp_q.tens;
      2'd2:    nib = disp_q.hundreds;
      default: nib = 4'd0;
    endcase
  end

  seg7_decode u_decode (
    .bcd_i (nib),
    .seg_o (dec_seg)
  );

  always_comb begin
    seg_d = dec_seg;
    if (!valid_q) begin
      seg_d = SegDash;
    end else begin
      unique case (idx_q)
        2'd3:    seg_d = disp_q.sign ? SegDash : SegBlank;
        2'd2:    seg_d = (disp_q.hundreds == 4'd0) ? SegBlank : dec_seg;
        2'd1:    seg_d = (disp_q.hundreds == 4'd0 && disp_q.tens == 4'd0) ? SegBlank : dec_seg;
        default: seg_d = dec_seg;
      endcase
    end
    an_d = tick ? 4'b1111 : ~(4'b0001 << idx_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= 16'd0;
      idx_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      disp_q     <= '0;
      valid_q    <= 1'b0;
      seg_q      <= SegBlank;
      an_q       <= 4'b1111;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      disp_q     <= disp_d;
      valid_q    <= valid_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan: cycle-count reference model plus directed
// literal checks and randomized data/reset traffic.
module tb_seg7_scan;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic       sign;
  logic [3:0] hundreds, tens, ones;
  logic       data_ready;
  logic [6:0] seg;
  logic [3:0] an;
  logic       valid;

  int n_chk  = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  // Reference model state: cycles since reset release, pending and shown values
  int          m_s;
  logic        m_pf, m_valid;
  logic [12:0] m_pv, m_dv;
  logic [6:0]  e_seg;
  logic [3:0]  e_an;
  logic        e_care;

  seg7_scan #(.DIV(16'd4)) dut (
    .clk        (clk),
    .rst        (rst),
    .sign       (sign),
    .hundreds   (hundreds),
    .tens       (tens),
    .ones       (ones),
    .data_ready (data_ready),
    .seg        (seg),
    .an         (an),
    .valid      (valid)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0000110;
    endcase
  endfunction

  // v = {sign, hundreds, tens, ones}
  function automatic logic [6:0] digit(input int pos, input logic shown, input logic [12:0] v);
    if (!shown) return 7'b0111111;
    case (pos)
      3: return v[12] ? 7'b0111111 : 7'b1111111;
      2: return (v[11:8] == 4'd0) ? 7'b1111111 : enc(v[11:8]);
      1: return (v[11:8] == 4'd0 && v[7:4] == 4'd0) ? 7'b1111111 : enc(v[7:4]);
      default: return enc(v[3:0]);
    endcase
  endfunction

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b want %b", name, $time, got, want);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s at %0t: wait expired", name, $time);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_s = 0; m_pf = 1'b0; m_valid = 1'b0; m_pv = '0; m_dv = '0;
      e_seg = 7'b1111111; e_an = 4'b1111; e_care = 1'b1;
    end else begin
      int  pos;
      bit  tk;
      pos    = (m_s / DIV) % 4;
      tk     = (m_s % DIV) == DIV - 1;
      e_an   = tk ? 4'b1111 : ~(4'b0001 << pos);
      e_seg  = digit(pos, m_valid, m_dv);
      e_care = !tk;
      if (tk && pos == 3 && m_pf) begin
        m_dv = m_pv; m_valid = 1'b1; m_pf = 1'b0;
      end
      if (data_ready) begin
        m_pv = {sign, hundreds, tens, ones}; m_pf = 1'b1;
      end
      m_s++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("an", {4'h0, an}, {4'h0, e_an});
      chk("valid", {7'h0, valid}, {7'h0, m_valid});
      if (e_care) chk("seg", {1'b0, seg}, {1'b0, e_seg});
    end
  end

  task automatic wait_an(input logic [3:0] a, input logic [6:0] s, input string name);
    int k = 0;
    do begin @(negedge clk); k++; end while (an !== a && k < 40);
    if (an !== a) timeout(name);
    else chk(name, {1'b0, seg}, {1'b0, s});
  endtask

  task automatic wait_wrap(input string name);
    int k = 0;
    do begin @(negedge clk); k++; end while ((m_s % FRAME) != 0 && k < 40);
    if ((m_s % FRAME) != 0) timeout(name);
  endtask

  task automatic pulse_at(input int phase, input logic s, input logic [3:0] h,
                          input logic [3:0] t, input logic [3:0] o);
    int k = 0;
    while ((m_s % FRAME) != phase && k < 40) begin @(negedge clk); k++; end
    if ((m_s % FRAME) != phase) timeout("pulse_phase");
    sign = s; hundreds = h; tens = t; ones = o; data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sign = 1'b0; hundreds = '0; tens = '0; ones = '0; data_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_seg", {1'b0, seg}, 8'h7F);
    chk("rst_an", {4'h0, an}, 8'h0F);
    chk("rst_valid", {7'h0, valid}, 8'h00);
    rst = 1'b0;

    // Idle scan before any data
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1)  begin chk("idle_an1", {4'h0, an}, 8'b0000_1110);
                         chk("idle_seg1", {1'b0, seg}, 8'b0011_1111); end
      if (k == 4)  chk("idle_tick_an", {4'h0, an}, 8'b0000_1111);
      if (k == 5)  chk("idle_an5", {4'h0, an}, 8'b0000_1101);
      if (k == 9)  chk("idle_an9", {4'h0, an}, 8'b0000_1011);
      if (k == 13) begin chk("idle_an13", {4'h0, an}, 8'b0000_0111);
                         chk("idle_seg13", {1'b0, seg}, 8'b0011_1111); end
      if (k == 16) chk("idle_valid", {7'h0, valid}, 8'h00);
    end

    // -127
    pulse_at(2, 1'b1, 4'd1, 4'd2, 4'd7);
    wait_wrap("wrap_a");
    wait_an(4'b1110, 7'b1111000, "a_d0");
    wait_an(4'b1101, 7'b0100100, "a_d1");
    wait_an(4'b1011, 7'b1111001, "a_d2");
    wait_an(4'b0111, 7'b0111111, "a_d3");
    chk("a_valid", {7'h0, valid}, 8'h01);

    // 5 with leading zeros suppressed
    pulse_at(2, 1'b0, 4'd0, 4'd0, 4'd5);
    wait_wrap("wrap_b");
    wait_an(4'b1110, 7'b0010010, "b_d0");
    wait_an(4'b1101, 7'b1111111, "b_d1");
    wait_an(4'b1011, 7'b1111111, "b_d2");
    wait_an(4'b0111, 7'b1111111, "b_d3");

    // 40 mid-frame, then 0x0C on the wrap cycle itself: 40 shows first, 0x0C a frame later
    pulse_at(5, 1'b0, 4'd0, 4'd4, 4'd0);
    pulse_at(FRAME - 1, 1'b0, 4'd0, 4'd0, 4'hC);
    wait_an(4'b1110, 7'b1000000, "c_d0");
    wait_an(4'b1101, 7'b0011001, "c_d1");
    wait_an(4'b1011, 7'b1111111, "c_d2");
    wait_wrap("wrap_d");
    wait_an(4'b1110, 7'b0000110, "d_d0");
    wait_an(4'b1101, 7'b1111111, "d_d1");

    // Reset with a value still pending: it must never reach the display
    pulse_at(3, 1'b1, 4'd9, 4'd9, 4'd9);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_seg", {1'b0, seg}, 8'h7F);
    chk("mrst_an", {4'h0, an}, 8'h0F);
    chk("mrst_valid", {7'h0, valid}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("mrst_valid_after", {7'h0, valid}, 8'h00);

    // Randomized traffic, occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst        = ($urandom_range(0, 399) == 0);
      data_ready = ($urandom_range(0, 7) == 0);
      sign       = 1'($urandom_range(0, 1));
      hundreds   = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      tens       = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      ones       = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    rst = 1'b0; data_ready = 1'b0;
    repeat (2 * FRAME) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter DIV, default 16'd25000, number of clk cycles per digit slot; legal range 2..65535.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 sign  input  1  1 = negative value, from the BCD converter.
REQ-005 hundreds  input  4  BCD hundreds digit.
REQ-006 tens  input  4  BCD tens digit.
REQ-007 ones  input  4  BCD ones digit.
REQ-008 data_ready  input  1  level; converter outputs valid while high.
REQ-009 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010 an  output  4  digit enables, active-low; an[0] = ones ... an[3] = sign position.
REQ-011 valid  output  1  high once at least one value has been committed for display.

Function
REQ-012 Prescaler counts 0..DIV-1 and wraps; tick is asserted in the cycle the count equals DIV-1.
REQ-013 On each tick, the 2-bit digit index advances 0->1->2->3->0.
REQ-014 During the tick cycle, an shall be 4'b1111 (anti-ghost blank); otherwise exactly one an bit is low, selected by the index.
REQ-015 Any cycle with data_ready=1 shall copy {sign,hundreds,tens,ones} into a pending register and set a pending flag.
REQ-016 When index wraps 3->0 with pending set, pending shall move to the display register, pending clears, and valid sets; the display register never changes mid-frame.
REQ-017 data_ready in the same cycle as a wrap shall commit the previous pending value and latch the new one as pending, so it shows at the next wrap.
REQ-018 Before valid, all four digits shall show '-' (7'b0111111).
REQ-019 Digit 3 shows '-' if sign=1, else blank (7'b1111111).
REQ-020 Digit 2 is blank if hundreds=0 (leading-zero suppression), else that digit.
REQ-021 Digit 1 is blank if hundreds=0 and tens=0, else that digit.
REQ-022 Digit 0 is always shown; a value of 0 displays '0' (7'b1000000).
REQ-023 Any BCD nibble >9 on a non-blanked digit shall display 'E' (7'b0000110).
REQ-024 Output encodings: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-025 seg and an shall be registered (one-cycle latency from the index/display register to the pins).

Reset
REQ-026 rst=1 at a clock edge clears the prescaler, index, pending flag, valid, and display/pending registers; seg=7'b1111111 and an=4'b1111 on the next cycle.
REQ-027 Reset asserted mid-frame or mid-pending shall discard pending data; after release, the first tick occurs DIV cycles later.

Structure
REQ-028 Shared package seg7_pkg holds segment pattern constants (digits 0-9, DASH, BLANK, ERR) and the digit-index width.
REQ-029 One sub-module, seg7_decode: combinational 4-bit BCD to 7-bit active-low pattern with ERR for values >9; instantiated once on the selected digit.

Verification (DIV=4)
REQ-030 Reset, then 16 cycles with no data_ready -> valid=0; each enabled digit shows 0111111; an cycles 1110,1101,1011,0111, with 1111 on tick cycles.
REQ-031 Pulse data_ready with sign=1, h=1, t=2, o=7 -> after the next wrap, valid=1; digits show '-','1','2','7'.
REQ-032 sign=0, h=0, t=0, o=5 -> digits 3..1 blank; digit 0 shows 0010010.
REQ-033 sign=0, h=0, t=4, o=0 -> digit 2 blank; digit 1 shows 0011001; digit 0 shows 1000000.
REQ-034 ones=4'hC -> digit 0 shows 0000110; data_ready applied on the wrap cycle -> the value appears one frame (16 cycles) later.
REQ-035 rst asserted mid-frame with pending set -> seg=1111111, an=1111, valid=0; the old value never displays.
